// File: rtl/display_arbiter_pkg.sv
// display_arbiter_pkg: shared state encoding, digit geometry and hold-counter width
package display_arbiter_pkg;
  localparam int DIGIT_W = 4;
  localparam int DIGIT_N = 4;
  localparam int DATA_W  = DIGIT_W * DIGIT_N;
  localparam int CNT_W   = 20;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_A   = 2'd1,
    OWN_B   = 2'd2,
    RELEASE = 2'd3
  } state_e;
  // Picks digit idx (0 = rightmost nibble) out of a packed digit word
  function automatic logic [DIGIT_W-1:0] nibble(input logic [DATA_W-1:0] d, input int idx);
    return d[idx*DIGIT_W +: DIGIT_W];
  endfunction
endpackage

// File: rtl/hold_timer.sv
// hold_timer: loadable down-counter that saturates at zero and flags it
module hold_timer
  import display_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 1000
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_Load,
  output logic o_Zero
);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Reload on a new ownership, otherwise count down and stick at zero
  always_comb cnt_d = i_Load ? RELOAD : (cnt_q == '0) ? '0 : cnt_q - ONE;
  // Counter register
  always_ff @(posedge i_Clk or negedge i_Rst_n)
    if (!i_Rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  assign o_Zero = (cnt_q == '0);
endmodule

// File: rtl/display_arbiter.sv
// display_arbiter: round-robin owner of a shared 4-digit display with a minimum hold time
module display_arbiter
  import display_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 1000
) (
  input  logic               i_Clk,
  input  logic               i_Rst_n,
  input  logic               i_Req_A,
  input  logic [DATA_W-1:0]  i_Datos_A,
  input  logic               i_Req_B,
  input  logic [DATA_W-1:0]  i_Datos_B,
  output logic               o_Gnt_A,
  output logic               o_Gnt_B,
  output logic [DIGIT_W-1:0] o_Datos_1,
  output logic [DIGIT_W-1:0] o_Datos_2,
  output logic [DIGIT_W-1:0] o_Datos_3,
  output logic [DIGIT_W-1:0] o_Datos_4,
  output logic               o_Ocupado
);
  state_e            state_q, state_d;
  logic              last_b_q, last_b_d;
  logic [DATA_W-1:0] dig_q, dig_d;
  logic              gnt_a_q, gnt_b_q, occ_q;
  logic              zero, load;

  hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
    .i_Clk  (i_Clk),
    .i_Rst_n(i_Rst_n),
    .i_Load (load),
    .o_Zero (zero)
  );

  // Next-state: round-robin on ties, early drop goes through RELEASE until hold expires
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (i_Req_A && (!i_Req_B || last_b_q)) ? OWN_A : i_Req_B ? OWN_B : IDLE;
      OWN_A:   state_d = !i_Req_A ? (zero ? IDLE : RELEASE) : (zero && i_Req_B) ? OWN_B : OWN_A;
      OWN_B:   state_d = !i_Req_B ? (zero ? IDLE : RELEASE) : (zero && i_Req_A) ? OWN_A : OWN_B;
      RELEASE: state_d = zero ? IDLE : RELEASE;
      default: state_d = IDLE;
    endcase
  end

  // Every entry into an owned state restarts the hold time and records the winner
  always_comb begin
    load     = (state_d == OWN_A && state_q != OWN_A) || (state_d == OWN_B && state_q != OWN_B);
    last_b_d = load ? (state_d == OWN_B) : last_b_q;
    dig_d    = (state_q == OWN_A && i_Req_A) ? i_Datos_A :
               (state_q == OWN_B && i_Req_B) ? i_Datos_B : dig_q;
  end

  // State, fairness, digit and output registers; reset favours A on the first tie
  always_ff @(posedge i_Clk or negedge i_Rst_n)
    if (!i_Rst_n) begin
      state_q  <= IDLE;
      last_b_q <= 1'b1;
      dig_q    <= '0;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      occ_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
      dig_q    <= dig_d;
      gnt_a_q  <= (state_d == OWN_A);
      gnt_b_q  <= (state_d == OWN_B);
      occ_q    <= (state_d != IDLE);
    end

  assign o_Gnt_A   = gnt_a_q;
  assign o_Gnt_B   = gnt_b_q;
  assign o_Ocupado = occ_q;
  assign o_Datos_1 = nibble(dig_q, 0);
  assign o_Datos_2 = nibble(dig_q, 1);
  assign o_Datos_3 = nibble(dig_q, 2);
  assign o_Datos_4 = nibble(dig_q, 3);
endmodule

// File: tb/tb_display_arbiter.sv
// tb_display_arbiter: directed checks of reset, tie fairness, early release, sole owner and async reset
module tb_display_arbiter;
  logic        clk = 1'b0;
  logic        rst_n, req_a, req_b;
  logic [15:0] da, db, last_db;
  logic        gnt_a, gnt_b, occ;
  logic [3:0]  d1, d2, d3, d4;
  logic [18:0] obs_v;
  int          n_cmp = 0;
  int          n_bad = 0;

  localparam logic [2:0] NONE = 3'b000, HELD = 3'b001, GA = 3'b101, GB = 3'b011;
  logic [18:0] tie_exp [12] = '{
    {GA, 16'h0000}, {GA, 16'h1579}, {GA, 16'h1579}, {GA, 16'h1579},
    {GB, 16'h1579}, {GB, 16'h2468}, {GB, 16'h2468}, {GB, 16'h2468},
    {GA, 16'h2468}, {GA, 16'h1579}, {GA, 16'h1579}, {GA, 16'h1579}
  };

  display_arbiter #(.HOLD_CYCLES(4)) dut (
    .i_Clk    (clk),
    .i_Rst_n  (rst_n),
    .i_Req_A  (req_a),
    .i_Datos_A(da),
    .i_Req_B  (req_b),
    .i_Datos_B(db),
    .o_Gnt_A  (gnt_a),
    .o_Gnt_B  (gnt_b),
    .o_Datos_1(d1),
    .o_Datos_2(d2),
    .o_Datos_3(d3),
    .o_Datos_4(d4),
    .o_Ocupado(occ)
  );

  always #5 clk = ~clk;
  assign obs_v = {gnt_a, gnt_b, occ, d4, d3, d2, d1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // Grants must never overlap, and any grant implies busy
  always @(negedge clk) begin
    chk("mutex", 32'(gnt_a & gnt_b), 32'd0);
    chk("occ_gnt", 32'((gnt_a | gnt_b) & ~occ), 32'd0);
  end

  initial begin
    rst_n = 1'b0; req_a = 1'b1; req_b = 1'b1; da = 16'h1579; db = 16'h2468;
    #20;
    chk("reset", 32'(obs_v), 32'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc;
      chk($sformatf("tie%0d", i), 32'(obs_v), 32'(tie_exp[i]));
    end
    rst_n = 1'b0; req_b = 1'b0; da = 16'h1234; db = 16'h5678;
    #1 chk("async_rst_a", 32'(obs_v), 32'd0);
    #2 rst_n = 1'b1;
    cyc; chk("rel_e1", 32'(obs_v), 32'({GA, 16'h0000}));
    cyc; chk("rel_e2", 32'(obs_v), 32'({GA, 16'h1234}));
    req_a = 1'b0; req_b = 1'b1;
    cyc; chk("rel_e3", 32'(obs_v), 32'({HELD, 16'h1234}));
    cyc; chk("rel_e4", 32'(obs_v), 32'({HELD, 16'h1234}));
    cyc; chk("rel_e5", 32'(obs_v), 32'({NONE, 16'h1234}));
    cyc; chk("rel_e6", 32'(obs_v), 32'({GB, 16'h1234}));
    cyc; chk("rel_e7", 32'(obs_v), 32'({GB, 16'h5678}));
    for (int i = 0; i < 20; i++) begin
      db = 16'h1000 + 16'(i * 16'h0123);
      cyc;
      chk($sformatf("sole%0d", i), 32'(obs_v), 32'({GB, db}));
    end
    last_db = db;
    req_b = 1'b0; req_a = 1'b1; da = 16'h9876;
    cyc; chk("drop_b", 32'(obs_v), 32'({NONE, last_db}));
    cyc; chk("gnt_a", 32'(obs_v), 32'({GA, last_db}));
    cyc; chk("dat_a", 32'(obs_v), 32'({GA, 16'h9876}));
    #3 rst_n = 1'b0;
    #1 chk("async_rst_b", 32'(obs_v), 32'd0);
    #2 rst_n = 1'b1;
    cyc; chk("post_rst_e1", 32'(obs_v), 32'({GA, 16'h0000}));
    cyc; chk("post_rst_e2", 32'(obs_v), 32'({GA, 16'h9876}));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 1000, minimum number of clock cycles a grant owner keeps the display (legal range 1..2^20-1).
REQ-002 i_Clk  input  1  system clock; all state changes on rising edge.
REQ-003 i_Rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_Req_A  input  1  requester A wants the display (level).
REQ-005 i_Datos_A  input  16  requester A digits; [3:0] digit 1 ... [15:12] digit 4.
REQ-006 i_Req_B  input  1  requester B wants the display (level).
REQ-007 i_Datos_B  input  16  requester B digits, same packing as A.
REQ-008 o_Gnt_A  output  1  A owns the display.
REQ-009 o_Gnt_B  output  1  B owns the display.
REQ-010 o_Datos_1..o_Datos_4  output  4 each  BCD digits driven into the 4-digit 7-segment display controller's data inputs 1..4.
REQ-011 o_Ocupado  output  1  high whenever state is not IDLE.

Function
REQ-012 States: IDLE, OWN_A, OWN_B, RELEASE; all outputs registered.
REQ-013 IDLE: only i_Req_A high -> OWN_A; only i_Req_B high -> OWN_B; both high -> requester not granted last (round-robin); neither -> stay.
REQ-014 Grant latency: request sampled high at edge k -> o_Gnt_x high after edge k; o_Gnt_A and o_Gnt_B never high simultaneously.
REQ-015 On entering OWN_x, hold counter loads HOLD_CYCLES-1 and decrements each cycle to 0, saturating at 0.
REQ-016 In OWN_x, on every edge where i_Req_x is high, o_Datos_1..4 load i_Datos_x nibbles [3:0],[7:4],[11:8],[15:12]; one-cycle data latency.
REQ-017 OWN_x, i_Req_x low, counter nonzero -> RELEASE; o_Gnt_x drops after that edge; digits frozen.
REQ-018 OWN_x, i_Req_x low, counter zero -> IDLE.
REQ-019 OWN_x, counter zero, i_Req_x high, other requester high -> direct switch to OWN_other (preemption), counter reloaded; grants swap on same edge, no overlap.
REQ-020 OWN_x, counter zero, other requester low -> stay in OWN_x indefinitely.
REQ-021 RELEASE: digits frozen, no grant, counter keeps decrementing; counter zero -> IDLE; requests ignored until IDLE.
REQ-022 IDLE and RELEASE hold last displayed digits (no blanking).
REQ-023 Last-grant register updates on every entry into OWN_A/OWN_B.
REQ-024 HOLD_CYCLES=1: counter zero on first owned cycle; preemption possible next edge.

Reset
REQ-025 i_Rst_n low asynchronously forces state IDLE, o_Gnt_A=0, o_Gnt_B=0, o_Ocupado=0, o_Datos_1..4=0, counter=0, last-grant=B (so A wins the first tie).
REQ-026 Reset asserted mid-grant drops the grant immediately without waiting for a clock edge; first arbitration occurs on the first edge after i_Rst_n rises.

Structure
REQ-027 Shared package holds state encoding (2-bit), digit width (4), digit count (4), and counter width constant (20).
REQ-028 One sub-module, hold_timer: load, decrement, saturating zero flag; arbiter FSM and digit registers in display_arbiter.

Verification (HOLD_CYCLES=4, 10 ns clock)
REQ-029 Reset: i_Rst_n=0 for 20 ns -> all outputs 0; release with both requests high -> o_Gnt_A=1 after first edge, o_Datos_1..4 = A data one edge later.
REQ-030 Tie fairness: A holds 0x1579, B 0x2468, both requesting continuously -> grant alternates A,B,A every 4 cycles; digits alternate 9,7,5,1 / 8,6,4,2.
REQ-031 Early release: A granted, drops req at cycle 2, B requests -> RELEASE for remaining 2 cycles, digits frozen, B granted only after counter zero.
REQ-032 Sole owner: only B requests for 20 cycles -> o_Gnt_B stays 1, digits track i_Datos_B with one-cycle latency, no IDLE transition.
REQ-033 Async reset mid-grant: i_Rst_n low between edges while o_Gnt_A=1 -> o_Gnt_A and digits 0 before next edge.
REQ-034 Assertion throughout all scenarios: never o_Gnt_A & o_Gnt_B; o_Ocupado equals (state != IDLE).
